// File: rtl/alu_pipe.sv
// Two-stage elastic ALU pipeline: stage 1 registers prepared operands, stage 2
// computes shift/rotate/logic/add results with zero, carry and overflow flags.
module alu_pipe #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [2:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Z,
    output logic             Cout,
    output logic             Ofl,
    output logic             ofl_sticky,
    input  logic             ofl_clr
);

    typedef enum logic [2:0] {
        OP_ROL = 3'b000,
        OP_SHL = 3'b001,
        OP_ROR = 3'b010,
        OP_SHR = 3'b011,
        OP_ADD = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_AND = 3'b111
    } op_e;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    op_e              op_q, op_d;
    logic             sign_q, sign_d;

    // Stage 2 (result) registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             cout_q, cout_d;
    logic             ofl_q, ofl_d;
    logic             sticky_q, sticky_d;

    logic             accept;
    logic             s2_load;
    logic [SHW-1:0]   cnt;
    logic [2*WIDTH-1:0] rol_full;
    logic [2*WIDTH-1:0] ror_full;
    logic [WIDTH:0]   sum;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // in_ready depends only on pipeline occupancy and out_ready, never on
    // in_valid, so no combinational in_valid -> out_valid path exists.
    assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign accept   = in_valid && in_ready;

    assign cnt      = b_q[SHW-1:0];
    // Rotates via a doubled operand so a zero count needs no special case.
    assign rol_full = {a_q, a_q} << cnt;
    assign ror_full = {a_q, a_q} >> cnt;
    assign sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        op_d       = op_q;
        sign_d     = sign_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            a_d        = invA ? ~A : A;
            b_d        = invB ? ~B : B;
            cin_d      = Cin;
            op_d       = op_e'(Op);
            sign_d     = sign;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        cout_d      = cout_q;
        ofl_d       = ofl_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            cout_d      = 1'b0;
            ofl_d       = 1'b0;
            case (op_q)
                OP_ROL:  out_d = rol_full[2*WIDTH-1:WIDTH];
                OP_SHL:  out_d = a_q << cnt;
                OP_ROR:  out_d = ror_full[WIDTH-1:0];
                OP_SHR:  out_d = a_q >> cnt;
                OP_ADD: begin
                    out_d  = sum[WIDTH-1:0];
                    cout_d = sum[WIDTH];
                    ofl_d  = sign_q ? ((a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (sum[WIDTH-1] != a_q[WIDTH-1]))
                                    : sum[WIDTH];
                end
                OP_OR:   out_d = a_q | b_q;
                OP_XOR:  out_d = a_q ^ b_q;
                default: out_d = a_q & b_q;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A consumed overflow beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (out_valid_q && out_ready && ofl_q) begin
            sticky_d = 1'b1;
        end else if (ofl_clr) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            op_q        <= OP_ROL;
            sign_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            cout_q      <= 1'b0;
            ofl_q       <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            op_q        <= op_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            cout_q      <= cout_d;
            ofl_q       <= ofl_d;
            sticky_q    <= sticky_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign Out        = out_q;
    assign Z          = (out_q == '0);
    assign Cout       = cout_q;
    assign Ofl        = ofl_q;
    assign ofl_sticky = sticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: driver tasks push hand-computed results into a
// queue; a negedge monitor pops and compares every consumed result.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, Cin, invA, invB, sign, out_ready, ofl_clr;
    logic [2:0]  Op;
    logic [15:0] A, B;
    logic        in_ready, out_valid, Z, Cout, Ofl, ofl_sticky;
    logic [15:0] Out;

    logic        in_valid8, out_ready8;
    logic [7:0]  A8, B8;
    logic        in_ready8, out_valid8, Z8, Cout8, Ofl8, sticky8;
    logic [7:0]  Out8;

    logic [18:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic        held_v = 1'b0;
    logic [15:0] held_out;
    logic        saw_bp = 1'b0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB), .sign(sign),
        .out_valid(out_valid), .out_ready(out_ready), .Out(Out), .Z(Z),
        .Cout(Cout), .Ofl(Ofl), .ofl_sticky(ofl_sticky), .ofl_clr(ofl_clr)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Cin(1'b0), .Op(3'b100), .invA(1'b0), .invB(1'b0),
        .sign(1'b1), .out_valid(out_valid8), .out_ready(out_ready8), .Out(Out8),
        .Z(Z8), .Cout(Cout8), .Ofl(Ofl8), .ofl_sticky(sticky8), .ofl_clr(1'b0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one op (caller is just after a posedge); returns just after the accepting edge.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input logic [2:0] op, input logic ia, input logic ib, input logic sg,
                         input logic [15:0] e_out, input logic e_z, input logic e_cout,
                         input logic e_ofl, input bit push);
        logic acc;
        acc = 1'b0;
        A = a; B = b; Cin = cin; Op = op; invA = ia; invB = ib; sign = sg;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        if (!acc) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: got in_ready=0 for 50 cycles expected acceptance");
        end else if (push) begin
            exp_q.push_back({e_out, e_z, e_cout, e_ofl});
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (held_v) check("stall_hold", Out, held_out);
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_result: got Out=0x%0h expected no result", Out);
                end else begin
                    check("result", {Out, Z, Cout, Ofl}, exp_q.pop_front());
                end
            end
            held_v   = !out_ready;
            held_out = Out;
        end else begin
            held_v = 1'b0;
        end
        if (!rst && in_valid && !in_ready) saw_bp = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 500000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Op = '0;
        invA = 1'b0; invB = 1'b0; sign = 1'b0; out_ready = 1'b1; ofl_clr = 1'b0;
        in_valid8 = 1'b0; A8 = '0; B8 = '0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out", Out, 16'h0000);
        check("rst_z", Z, 1);
        check("rst_cout", Cout, 0);
        check("rst_ofl", Ofl, 0);
        check("rst_sticky", ofl_sticky, 0);

        // Signed overflow with latency and sticky checks
        issue(16'h7FFF, 16'h0001, 0, 3'b100, 0, 0, 1, 16'h8000, 0, 0, 1, 1);
        @(negedge clk); check("lat_edge_n", out_valid, 0);
        @(negedge clk); check("lat_edge_n1", out_valid, 1);
        @(negedge clk); check("sticky_after_consume", ofl_sticky, 1);
        @(posedge clk); #1;

        issue(16'hFFFF, 16'h0001, 0, 3'b100, 0, 0, 0, 16'h0000, 1, 1, 1, 1);
        issue(16'hFFFF, 16'h0001, 0, 3'b100, 0, 0, 1, 16'h0000, 1, 1, 0, 1);
        issue(16'h8001, 16'h0004, 0, 3'b000, 0, 0, 0, 16'h0018, 0, 0, 0, 1);
        issue(16'h8001, 16'h0004, 0, 3'b001, 0, 0, 0, 16'h0010, 0, 0, 0, 1);
        issue(16'h8001, 16'h0004, 0, 3'b010, 0, 0, 0, 16'h1800, 0, 0, 0, 1);
        issue(16'h8001, 16'h0004, 0, 3'b011, 0, 0, 0, 16'h0800, 0, 0, 0, 1);
        issue(16'h8001, 16'hFFFE, 0, 3'b000, 0, 1, 0, 16'h0003, 0, 0, 0, 1);
        issue(16'h00F0, 16'h0F0F, 0, 3'b101, 1, 0, 0, 16'hFF0F, 0, 0, 0, 1);
        issue(16'h00F0, 16'h0FF0, 0, 3'b110, 0, 0, 0, 16'h0F00, 0, 0, 0, 1);
        issue(16'h00F0, 16'h0F0F, 0, 3'b111, 0, 0, 0, 16'h0000, 1, 0, 0, 1);
        wait_drain();

        // Six back-to-back ADDs with a three-cycle output stall
        saw_bp = 1'b0;
        fork
            begin
                issue(16'h0001, 16'h0002, 0, 3'b100, 0, 0, 0, 16'h0003, 0, 0, 0, 1);
                issue(16'h1234, 16'h1111, 1, 3'b100, 0, 0, 0, 16'h2346, 0, 0, 0, 1);
                issue(16'h00FF, 16'h0001, 0, 3'b100, 0, 0, 0, 16'h0100, 0, 0, 0, 1);
                issue(16'h8000, 16'h8000, 0, 3'b100, 0, 0, 0, 16'h0000, 1, 1, 1, 1);
                issue(16'h4000, 16'h4000, 1, 3'b100, 0, 0, 0, 16'h8001, 0, 0, 0, 1);
                issue(16'hFFF0, 16'h0010, 0, 3'b100, 0, 0, 0, 16'h0000, 1, 1, 1, 1);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("in_ready_drop", saw_bp, 1);

        // Sticky clear, then set-wins-over-clear
        ofl_clr = 1'b1;
        @(posedge clk); #1 ofl_clr = 1'b0;
        check("sticky_clr", ofl_sticky, 0);
        out_ready = 1'b0;
        issue(16'h7FFF, 16'h0001, 0, 3'b100, 0, 0, 1, 16'h8000, 0, 0, 1, 1);
        @(posedge clk); #1;
        check("stalled_valid", out_valid, 1);
        out_ready = 1'b1; ofl_clr = 1'b1;
        @(posedge clk); #1 ofl_clr = 1'b0;
        check("sticky_set_wins", ofl_sticky, 1);
        ofl_clr = 1'b1;
        @(posedge clk); #1 ofl_clr = 1'b0;
        check("sticky_clr_alone", ofl_sticky, 0);
        wait_drain();

        // Reset with two ops in flight
        out_ready = 1'b0;
        issue(16'h0005, 16'h0006, 0, 3'b100, 0, 0, 0, 16'h000B, 0, 0, 0, 0);
        issue(16'h0007, 16'h0008, 0, 3'b100, 0, 0, 0, 16'h000F, 0, 0, 0, 0);
        check("full_in_ready", in_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out", Out, 16'h0000);
        check("midrst_z", Z, 1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // WIDTH=8 signed ADD
        A8 = 8'h7F; B8 = 8'h01; in_valid8 = 1'b1;
        @(negedge clk); check("w8_in_ready", in_ready8, 1);
        @(posedge clk); #1 in_valid8 = 1'b0;
        @(negedge clk); check("w8_lat_n", out_valid8, 0);
        @(negedge clk);
        check("w8_out_valid", out_valid8, 1);
        check("w8_out", Out8, 8'h80);
        check("w8_ofl", Ofl8, 1);
        check("w8_cout", Cout8, 0);
        check("w8_z", Z8, 0);
        @(posedge clk); #1;

        check("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the 16-bit combinational ALU. Accepts one operation per cycle over a valid/ready handshake, applies optional operand inversion, then computes one of eight shift/rotate/logic/add operations. Returns the result with zero, carry and overflow flags, plus a sticky overflow bit. Sits between the decode/issue logic and writeback, and absorbs writeback back-pressure without dropping operations.

## Interface
- WIDTH, 16, operand/result width; power of two, at least 4
- SHW, $clog2(WIDTH), shift-count width (derived, not overridden)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented on A/B/Cin/Op/invA/invB/sign
- in_ready  out  1  stage 1 can accept this cycle
- A, B  in  WIDTH  operands
- Cin  in  1  carry-in for ADD
- Op  in  3  opcode (below)
- invA, invB  in  1  bitwise-invert A / B before use
- sign  in  1  1 = signed overflow rule, 0 = unsigned
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- Out  out  WIDTH  result
- Z  out  1  Out == 0
- Cout  out  1  adder carry-out (ADD only, else 0)
- Ofl  out  1  overflow of this result (ADD only, else 0)
- ofl_sticky  out  1  OR of Ofl over all consumed results since clear
- ofl_clr  in  1  clear ofl_sticky

## Operation
- Operand prep in stage 1: a = invA ? ~A : A; b = invB ? ~B : B. Shift count = b[SHW-1:0].
- Op 000 rotate left; 001 shift left logical; 010 rotate right; 011 shift right logical. Count 0 passes a unchanged.
- Op 100 ADD: {Cout,Out} = a + b + Cin, WIDTH+1 bits. 101 OR; 110 XOR; 111 AND.
- Ofl for ADD: sign=1 means a[MSB]==b[MSB] and Out[MSB]!=a[MSB]; sign=0 means Ofl = Cout. Non-ADD: Ofl=0, Cout=0.
- Z is computed from the registered Out.
- Stage 1 registers a, b, Cin, Op and sign when in_valid && in_ready. Stage 2 computes and registers Out/Z/Cout/Ofl.
- Elastic pipeline:
  - s2 loads when s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2 loads this cycle.
  - No combinational path from in_valid to out_valid.
- ofl_sticky sets on a cycle with out_valid && out_ready && Ofl.
  - ofl_clr clears it. Simultaneous set and clear: set wins, so the bit is 1 next cycle.
- Data held in a stalled stage stays stable until consumed; inputs that are not accepted are ignored.

## Timing
- Reset: s1_valid=0, out_valid=0, Out=0, Z=1, Cout=0, Ofl=0, ofl_sticky=0; in_ready=1 in the first cycle after reset.
- Reset mid-operation discards both stages; no result is emitted for in-flight ops.
- Latency: accepted at edge N, out_valid=1 after edge N+1 (two-stage latency 2 cycles, input capture to result visible).
- Throughput: 1 op/cycle while out_ready=1.
- Back-pressure:
  - out_ready=0 with both stages full forces in_ready=0 combinationally in that same cycle.
  - On the cycle out_ready returns to 1, s2 consumes, s1 advances and in_ready=1: zero-bubble restart.
- Capacity: 2 operations in flight maximum.

## Test plan
- Reset, then WIDTH=16 ADD A=0x7FFF B=0x0001 Cin=0 sign=1 -> Out=0x8000, Ofl=1, Cout=0, Z=0, out_valid exactly 2 cycles after accept; ofl_sticky=1 after consume.
- ADD A=0xFFFF B=0x0001 sign=0 -> Out=0x0000, Z=1, Cout=1, Ofl=1. Same with sign=1 -> Ofl=0.
- Shifts on A=0x8001, B=4: op000 -> 0x0018, op001 -> 0x0010, op010 -> 0x1800, op011 -> 0x0800. invB=1 with B=0xFFFE gives count 1: rotate left -> 0x0003.
- Stream of 6 back-to-back ADDs, out_ready low for cycles 3-5:
  - in_ready drops while both stages are full.
  - Results appear in order, with no loss or duplication.
  - Out stays stable while stalled.
- ofl_clr asserted on the same cycle an overflowing result is consumed -> ofl_sticky=1. ofl_clr alone on the next cycle -> 0.
- Assert rst while 2 ops are in flight -> next cycle out_valid=0, in_ready=1, Out=0; no stale result emitted afterwards. Repeat the ADD check with WIDTH=8 (0x7F+0x01 signed -> 0x80, Ofl=1).
